// File: rtl/tx_pkg.sv
// Shared types and constants for the UART TX FIFO write-side arbiter.
// Sources use ASCII_LF to decide when to drive req_last.
package tx_pkg;

  localparam int         BYTE_W   = 8;
  localparam int         CNT_W    = 8;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: first set bit scanning ptr+1, ptr+2, ...
// Ports: i_req requests, i_ptr last owner, o_pick one-hot winner, o_valid any req.
module arb_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_valid
);

  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_hi_pick;
  logic [N_REQ-1:0] w_lo_pick;

  // Requests above the pointer win; otherwise wrap to the lowest index.
  always_comb begin
    w_hi      = '0;
    w_hi_pick = '0;
    w_lo_pick = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_hi[j] = i_req[j] && (IDX_W'(j) > i_ptr);
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_hi[j]) begin
        w_hi_pick    = '0;
        w_hi_pick[j] = 1'b1;
      end
      if (i_req[j]) begin
        w_lo_pick    = '0;
        w_lo_pick[j] = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;
  assign o_pick  = (|w_hi) ? w_hi_pick : w_lo_pick;

endmodule

// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between N_REQ
// byte sources; a grant is held for a whole burst so lines never interleave.
// Ports: clk/rst (async, active-high); req_valid/req_data/req_last/req_ready
// per source; fifo_full in, fifo_we/fifo_wdata out; grant one-hot, busy.
module tx_fifo_arbiter
  import tx_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int MAX_BURST    = 80,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_we,
  output logic [BYTE_W-1:0]       fifo_wdata,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int              IDX_W  = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] MAX_B  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] IDLE_T = CNT_W'(IDLE_TIMEOUT);

  state_t             r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [IDX_W-1:0]   r_gidx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   r_idle_cnt;
  logic [BYTE_W-1:0]  r_wdata;
  logic               r_busy;

  logic [N_REQ-1:0]   w_pick;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [BYTE_W-1:0]  w_bytes [N_REQ];
  logic               w_in_grant;
  logic               w_own_vld;
  logic               w_own_last;
  logic [BYTE_W-1:0]  w_own_data;
  logic               w_we;
  logic               w_last_end;
  logic               w_beat_end;
  logic               w_idle_end;
  logic               w_release;

  arb_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_pick[j]) w_pick_idx = IDX_W'(j);
    end
  end

  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      w_bytes[j] = req_data[BYTE_W*j +: BYTE_W];
    end
  end

  assign w_in_grant = (r_state == ST_GRANT);
  assign w_own_vld  = w_in_grant & req_valid[r_gidx];
  assign w_own_last = req_last[r_gidx];
  assign w_own_data = w_bytes[r_gidx];
  assign w_we       = w_own_vld & ~fifo_full;

  // Last and MAX_BURST on the same beat collapse into one release.
  assign w_last_end = w_we & w_own_last;
  assign w_beat_end = w_we & ((r_beat_cnt + 8'd1) == MAX_B);
  // A full-FIFO stall with valid data is not idle time.
  assign w_idle_end = w_in_grant & ~w_own_vld
                    & ((r_idle_cnt + 8'd1) == IDLE_T);
  assign w_release  = w_last_end | w_beat_end | w_idle_end;

  // r_grant is zero outside GRANT, so this also zeroes ready in IDLE.
  assign req_ready  = r_grant & {N_REQ{~fifo_full}};
  assign fifo_we    = w_we;
  assign fifo_wdata = w_we ? w_own_data : r_wdata;
  assign grant      = r_grant;
  assign busy       = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= IDX_W'(N_REQ - 1);
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_we) r_wdata <= w_own_data;
          if (w_release) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_rr_ptr   <= r_gidx;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
          end else if (w_we) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            r_idle_cnt <= '0;
          end else if (!w_own_vld) begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Scoreboard bench for tx_fifo_arbiter (N_REQ=2, MAX_BURST=4, IDLE_TIMEOUT=3).
// Sources are byte queues; expected FIFO bytes are queued and popped on fifo_we.
module tb_tx_fifo_arbiter;
  import tx_pkg::*;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_we;
  logic [7:0]     fifo_wdata;
  logic [N-1:0]   grant;
  logic           busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] sb[$];
  int         wcyc[$];
  logic [N-1:0] gq_g[$];
  int         gq_gap[$];
  bit         full_cmd = 1'b0;
  int         cyc = 0;
  int         zero_run = 0;
  logic [N-1:0] prev_g = '0;
  logic [7:0] mon_exp;

  tx_fifo_arbiter #(
    .N_REQ        (N),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic src(input int s, input logic [7:0] d, input logic l);
    if (s == 0) q0.push_back({l, d});
    else        q1.push_back({l, d});
  endtask

  task automatic ex(input logic [7:0] d);
    sb.push_back(d);
  endtask

  function automatic logic [N-1:0] gat(input int i);
    return (i < gq_g.size()) ? gq_g[i] : '1;
  endfunction

  function automatic int gapat(input int i);
    return (i < gq_gap.size()) ? gq_gap[i] : -1;
  endfunction

  function automatic int wat(input int i);
    return (i < wcyc.size()) ? wcyc[i] : -100;
  endfunction

  // Source drivers: present queue heads just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      req_valid[0] = 1'b1;
      req_last[0]  = q0[0][8];
      req_data[7:0] = q0[0][7:0];
    end else begin
      req_valid[0] = 1'b0;
      req_last[0]  = 1'b0;
      req_data[7:0] = 8'h00;
    end
    if (q1.size() > 0) begin
      req_valid[1] = 1'b1;
      req_last[1]  = q1[0][8];
      req_data[15:8] = q1[0][7:0];
    end else begin
      req_valid[1] = 1'b0;
      req_last[1]  = 1'b0;
      req_data[15:8] = 8'h00;
    end
    fifo_full = full_cmd;
  end

  // Monitor on the falling edge: handshakes, FIFO writes, grant history.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      zero_run = 0;
      prev_g   = '0;
    end else begin
      chk("inv_grant_onehot", 32'($onehot0(grant)), 1);
      chk("inv_ready_onehot", 32'($onehot0(req_ready)), 1);
      chk("inv_we_full", 32'(fifo_we & fifo_full), 0);
      chk("we_vs_handshake", 32'(fifo_we),
          32'(|(req_valid & req_ready)));
      if (req_valid[0] && req_ready[0] && q0.size() > 0)
        void'(q0.pop_front());
      if (req_valid[1] && req_ready[1] && q1.size() > 0)
        void'(q1.pop_front());
      if (fifo_we) begin
        if (sb.size() == 0) begin
          chk("fifo_extra_write", 32'(fifo_wdata), 32'hFFFF_FFFF);
        end else begin
          mon_exp = sb.pop_front();
          chk("fifo_data", 32'(fifo_wdata), 32'(mon_exp));
          wcyc.push_back(cyc);
        end
      end
      if (grant == '0) begin
        zero_run++;
      end else begin
        if (prev_g == '0) begin
          gq_g.push_back(grant);
          gq_gap.push_back(zero_run);
        end
        zero_run = 0;
      end
      prev_g = grant;
    end
  end

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((q0.size() + q1.size() + sb.size()) != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(n < budget), 1);
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(n < budget), 1);
  endtask

  task automatic newtest();
    @(posedge clk);
    gq_g.delete();
    gq_gap.delete();
    wcyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(fifo_we), 0);
    chk("rst_wdata", 32'(fifo_wdata), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;

    // T1: reset in the middle of a burst
    newtest();
    src(0, 8'h01, 1'b0);
    src(0, 8'h02, 1'b0);
    src(0, 8'h03, 1'b0);
    ex(8'h01);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t1_first_write", 32'(n < 20), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("t1_async_we", 32'(fifo_we), 0);
    @(negedge clk);
    #1;
    chk("t1_grant", 32'(grant), 0);
    chk("t1_we", 32'(fifo_we), 0);
    chk("t1_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    newtest();
    src(0, 8'hA0, 1'b1);
    src(1, 8'hB0, 1'b1);
    ex(8'hA0);
    ex(8'hB0);
    drain("t1", 40);
    chk("t1_ngrants", 32'(gq_g.size()), 2);
    chk("t1_g0", 32'(gat(0)), 32'h1);
    chk("t1_g1", 32'(gat(1)), 32'h2);

    // T2: single source "AB\n" then one more line
    newtest();
    src(0, 8'h41, 1'b0);
    src(0, 8'h42, 1'b0);
    src(0, ASCII_LF, 1'b1);
    src(0, 8'h58, 1'b1);
    ex(8'h41);
    ex(8'h42);
    ex(ASCII_LF);
    ex(8'h58);
    drain("t2", 40);
    chk("t2_ngrants", 32'(gq_g.size()), 2);
    chk("t2_g0", 32'(gat(0)), 32'h1);
    chk("t2_g1", 32'(gat(1)), 32'h1);
    chk("t2_gap", 32'(gapat(1)), 1);
    chk("t2_consecutive", 32'(wat(2) - wat(0)), 2);
    chk("t2_regrant_lat", 32'(wat(3) - wat(2)), 2);

    // T3: contention, last every 2nd byte; pointer now favours req1
    newtest();
    src(0, 8'h10, 1'b0);
    src(0, 8'h11, 1'b1);
    src(0, 8'h12, 1'b0);
    src(0, 8'h13, 1'b1);
    src(1, 8'h20, 1'b0);
    src(1, 8'h21, 1'b1);
    src(1, 8'h22, 1'b0);
    src(1, 8'h23, 1'b1);
    ex(8'h20);
    ex(8'h21);
    ex(8'h10);
    ex(8'h11);
    ex(8'h22);
    ex(8'h23);
    ex(8'h12);
    ex(8'h13);
    drain("t3", 60);
    chk("t3_ngrants", 32'(gq_g.size()), 4);
    chk("t3_g0", 32'(gat(0)), 32'h2);
    chk("t3_g1", 32'(gat(1)), 32'h1);
    chk("t3_g2", 32'(gat(2)), 32'h2);
    chk("t3_g3", 32'(gat(3)), 32'h1);
    for (int i = 1; i < 4; i++) chk("t3_gap", 32'(gapat(i)), 1);

    // T4: MAX_BURST forces release to a waiting requester
    newtest();
    for (int i = 0; i < 6; i++) src(0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 4; i++) ex(8'(8'h30 + i));
    ex(8'h40);
    ex(8'h34);
    ex(8'h35);
    n = 0;
    while (sb.size() == 7 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t4_first_write", 32'(n < 20), 1);
    src(1, 8'h40, 1'b1);
    drain("t4", 60);
    chk("t4_ngrants", 32'(gq_g.size()), 3);
    chk("t4_g0", 32'(gat(0)), 32'h1);
    chk("t4_g1", 32'(gat(1)), 32'h2);
    chk("t4_g2", 32'(gat(2)), 32'h1);
    chk("t4_burst_consec", 32'(wat(3) - wat(0)), 3);
    chk("t4_release_lat", 32'(wat(4) - wat(3)), 2);

    // T5: FIFO full for 5 cycles mid-burst
    newtest();
    src(0, 8'h70, 1'b0);
    src(0, 8'h71, 1'b0);
    src(0, 8'h72, 1'b0);
    src(0, 8'h73, 1'b1);
    ex(8'h70);
    ex(8'h71);
    ex(8'h72);
    ex(8'h73);
    n = 0;
    while (sb.size() > 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t5_two_writes", 32'(n < 20), 1);
    full_cmd = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 5; i++) begin
      chk("t5_full_grant", 32'(grant), 32'h1);
      chk("t5_full_we", 32'(fifo_we), 0);
      chk("t5_full_ready", 32'(req_ready), 0);
      if (i < 4) begin
        @(posedge clk);
        #2;
      end
    end
    full_cmd = 1'b0;
    drain("t5", 40);
    chk("t5_ngrants", 32'(gq_g.size()), 1);
    chk("t5_g0", 32'(gat(0)), 32'h1);

    // T6: idle timeout hands the port to req1
    newtest();
    src(0, 8'h80, 1'b0);
    ex(8'h80);
    ex(8'h90);
    n = 0;
    while (sb.size() == 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t6_first_write", 32'(n < 20), 1);
    src(1, 8'h90, 1'b1);
    drain("t6", 40);
    chk("t6_ngrants", 32'(gq_g.size()), 2);
    chk("t6_g0", 32'(gat(0)), 32'h1);
    chk("t6_g1", 32'(gat(1)), 32'h2);
    chk("t6_gap", 32'(gapat(1)), 1);
    chk("t6_timeout_lat", 32'(wat(1) - wat(0)), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
